// File: rtl/sccb_pkg.sv
// -----------------------------------------------------------------------------
// sccb_pkg
//   Shared definitions for the SCCB register-table player and its ROM:
//   bridge command encodings, the data-valid response code, the table
//   end/delay markers and the sequencer state type.
//   Optional feature macro: SCCB_INIT_VERIFY_EN (adds read-back verify states).
// -----------------------------------------------------------------------------
package sccb_pkg;

   localparam logic [2:0]  CMD_IDLE     = 3'b000;
   localparam logic [2:0]  CMD_WR       = 3'b001;
   localparam logic [2:0]  CMD_RD       = 3'b010;

   localparam logic [1:0]  RESP_DVA     = 2'b01;

   localparam logic [15:0] END_MARKER   = 16'hFEFF;
   localparam logic [7:0]  DELAY_MARKER = 8'hFF;

   typedef enum logic [3:0] {
      ST_IDLE         = 4'd0,
      ST_FETCH        = 4'd1,
      ST_DECODE       = 4'd2,
      ST_ISSUE        = 4'd3,
      ST_WAIT_DONE    = 4'd4,
      ST_DELAY        = 4'd5,
      ST_NEXT         = 4'd6,
      ST_FIN          = 4'd7,
      ST_ERR          = 4'd8
`ifdef SCCB_INIT_VERIFY_EN
      ,
      ST_VERIFY_ISSUE = 4'd9,
      ST_VERIFY_WAIT  = 4'd10
`endif
   } state_t;

   // Playback is in progress everywhere except the three resting states.
   function automatic logic state_busy(input state_t s);
      return !(s inside {ST_IDLE, ST_FIN, ST_ERR});
   endfunction

endpackage

// File: rtl/sccb_init_rom.sv
// -----------------------------------------------------------------------------
// sccb_init_rom
//   Synchronous 256x16 register table for sccb_init_seq. Each entry is
//   {reg_addr, value}; {8'hFF, n} is an n-tick delay and 16'hFEFF ends the
//   table. Data appears one clock after the address.
//   Ports:
//     i_clk   in   1   clock (same as the sequencer)
//     i_addr  in   8   table index
//     o_data  out  16  registered table entry
// -----------------------------------------------------------------------------
module sccb_init_rom
   import sccb_pkg::*;
(
   input  logic        i_clk,
   input  logic [7:0]  i_addr,
   output logic [15:0] o_data
);

   always_ff @(posedge i_clk) begin
      case (i_addr)
         8'd0:    o_data <= 16'h1280;
         8'd1:    o_data <= {DELAY_MARKER, 8'h02};
         8'd2:    o_data <= 16'h1101;
         default: o_data <= END_MARKER;
      endcase
   end

endmodule

// File: rtl/sccb_init_seq.sv
// -----------------------------------------------------------------------------
// sccb_init_seq
//   Plays a {reg_addr, value} table from an external synchronous ROM into an
//   SCCB bridge as write commands, with delay entries and an end marker.
//   Every bridge handshake phase is guarded by a timeout; running past
//   index 8'hFF without an end marker is an error.
//   Optional feature macro: SCCB_INIT_VERIFY_EN -- each write is read back
//   and compared; a mismatch is an error.
//   Ports:
//     sccb_clk      in   1   clock, shared with the bridge
//     sccb_reset_n  in   1   asynchronous active-low reset
//     start         in   1   pulse: begin playback (ignored while busy)
//     mcmd          out  3   bridge command (idle/write/read)
//     maddr         out  15  {DEV_ID, reg_addr}
//     mdata         out  8   write data
//     scmdaccept    in   1   bridge idle/accept
//     sresp         in   2   bridge response (DVA = data valid)
//     sdata         in   8   bridge read data
//     rom_addr      out  8   table index
//     rom_data      in   16  table entry, valid 1 cycle after rom_addr
//     busy          out  1   playback in progress
//     done          out  1   table end reached cleanly (sticky)
//     error         out  1   timeout / overrun / verify mismatch (sticky)
//     err_addr      out  8   rom_addr of the first failing entry
// -----------------------------------------------------------------------------
module sccb_init_seq
   import sccb_pkg::*;
#(
   parameter logic [6:0]  DEV_ID     = 7'h21,
   parameter logic [15:0] DELAY_UNIT = 16'd50000,
   parameter logic [19:0] TIMEOUT    = 20'hFFFFF
)
(
   input  logic        sccb_clk,
   input  logic        sccb_reset_n,
   input  logic        start,
   output logic [2:0]  mcmd,
   output logic [14:0] maddr,
   output logic [7:0]  mdata,
   input  logic        scmdaccept,
   input  logic [1:0]  sresp,
   input  logic [7:0]  sdata,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  err_addr
);

   state_t      r_state;
   logic [2:0]  r_mcmd;
   logic [14:0] r_maddr;
   logic [7:0]  r_mdata;
   logic [7:0]  r_rom_addr;
   logic        r_done;
   logic        r_error;
   logic [7:0]  r_err_addr;
   logic [19:0] r_tmo;
   logic [23:0] r_dly;

   logic [23:0] w_dly_prod;
   logic        w_tmo_hit;

   assign w_dly_prod = {16'd0, rom_data[7:0]} * {8'd0, DELAY_UNIT};
   // A phase may last TIMEOUT cycles; the cycle after that is the error.
   assign w_tmo_hit  = (r_tmo == TIMEOUT - 20'd1);

`ifndef SCCB_INIT_VERIFY_EN
   logic w_unused;
   assign w_unused = ^{sresp, sdata};
`endif

   always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
      if (!sccb_reset_n) begin
         r_state    <= ST_IDLE;
         r_mcmd     <= CMD_IDLE;
         r_maddr    <= '0;
         r_mdata    <= '0;
         r_rom_addr <= '0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_err_addr <= '0;
         r_tmo      <= '0;
         r_dly      <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_FIN, ST_ERR: begin
               if (start) begin
                  r_done     <= 1'b0;
                  r_error    <= 1'b0;
                  r_err_addr <= '0;
                  r_rom_addr <= '0;
                  r_state    <= ST_FETCH;
               end
            end

            ST_FETCH: r_state <= ST_DECODE;

            ST_DECODE: begin
               if (rom_data == END_MARKER) begin
                  r_done  <= 1'b1;
                  r_state <= ST_FIN;
               end else if (rom_data[15:8] == DELAY_MARKER) begin
                  if (rom_data[7:0] == 8'd0) begin
                     r_state <= ST_NEXT;
                  end else begin
                     r_dly   <= w_dly_prod - 24'd1;
                     r_state <= ST_DELAY;
                  end
               end else begin
                  r_maddr <= {DEV_ID, rom_data[15:8]};
                  r_mdata <= rom_data[7:0];
                  r_mcmd  <= CMD_WR;
                  r_tmo   <= '0;
                  r_state <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               if (!scmdaccept) begin
                  r_mcmd  <= CMD_IDLE;
                  r_tmo   <= '0;
                  r_state <= ST_WAIT_DONE;
               end else if (w_tmo_hit) begin
                  r_mcmd     <= CMD_IDLE;
                  r_error    <= 1'b1;
                  r_err_addr <= r_rom_addr;
                  r_state    <= ST_ERR;
               end else begin
                  r_tmo <= r_tmo + 20'd1;
               end
            end

            ST_WAIT_DONE: begin
               if (scmdaccept) begin
`ifdef SCCB_INIT_VERIFY_EN
                  r_mcmd  <= CMD_RD;
                  r_tmo   <= '0;
                  r_state <= ST_VERIFY_ISSUE;
`else
                  r_state <= ST_NEXT;
`endif
               end else if (w_tmo_hit) begin
                  r_mcmd     <= CMD_IDLE;
                  r_error    <= 1'b1;
                  r_err_addr <= r_rom_addr;
                  r_state    <= ST_ERR;
               end else begin
                  r_tmo <= r_tmo + 20'd1;
               end
            end

`ifdef SCCB_INIT_VERIFY_EN
            ST_VERIFY_ISSUE: begin
               if (!scmdaccept) begin
                  r_mcmd  <= CMD_IDLE;
                  r_tmo   <= '0;
                  r_state <= ST_VERIFY_WAIT;
               end else if (w_tmo_hit) begin
                  r_mcmd     <= CMD_IDLE;
                  r_error    <= 1'b1;
                  r_err_addr <= r_rom_addr;
                  r_state    <= ST_ERR;
               end else begin
                  r_tmo <= r_tmo + 20'd1;
               end
            end

            // Read data is compared on the single DVA cycle; r_mdata still
            // holds the value that was written.
            ST_VERIFY_WAIT: begin
               if (sresp == RESP_DVA) begin
                  if (sdata != r_mdata) begin
                     r_error    <= 1'b1;
                     r_err_addr <= r_rom_addr;
                     r_state    <= ST_ERR;
                  end else begin
                     r_state <= ST_NEXT;
                  end
               end else if (w_tmo_hit) begin
                  r_mcmd     <= CMD_IDLE;
                  r_error    <= 1'b1;
                  r_err_addr <= r_rom_addr;
                  r_state    <= ST_ERR;
               end else begin
                  r_tmo <= r_tmo + 20'd1;
               end
            end
`endif

            ST_DELAY: begin
               if (r_dly == 24'd0) r_state <= ST_NEXT;
               else                r_dly   <= r_dly - 24'd1;
            end

            ST_NEXT: begin
               if (r_rom_addr == 8'hFF) begin
                  r_error    <= 1'b1;
                  r_err_addr <= r_rom_addr;
                  r_state    <= ST_ERR;
               end else begin
                  r_rom_addr <= r_rom_addr + 8'd1;
                  r_state    <= ST_FETCH;
               end
            end

            default: begin
               r_mcmd  <= CMD_IDLE;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mcmd     = r_mcmd;
   assign maddr    = r_maddr;
   assign mdata    = r_mdata;
   assign rom_addr = r_rom_addr;
   assign busy     = state_busy(r_state);
   assign done     = r_done;
   assign error    = r_error;
   assign err_addr = r_err_addr;

endmodule
